bp_fe_realigner: RTL

Front-end packing stage that sits directly upstream of the backend issue queue. It takes raw fetch blocks from the I$ response path and resolves 16-bit halfword boundaries. It carries a 32-bit instruction that straddles two fetch blocks in a residue register, and emits one halfword-aligned packet per fetch block. The packet holds only complete instructions, with a halfword count, so the issue queue can expand and size each instruction without tracking partial encodings.

---
 rtl/bp_fe_realigner_if.sv | 23 ++
 rtl/bp_fe_realigner.sv | 96 +++++++++
 2 files changed

// File: rtl/bp_fe_realigner_if.sv
// bp_fe_realigner_if: fetch-block input and aligned-packet output bus of the realigner
interface bp_fe_realigner_if #(parameter int vaddr_width_p = 39, parameter int fetch_width_p = 32);
  localparam int cnt_w = $clog2(fetch_width_p/16 + 2);
  logic fetch_v_i;
  logic fetch_ready_and_o;
  logic [vaddr_width_p-1:0] fetch_pc_i;
  logic [fetch_width_p-1:0] fetch_data_i;
  logic v_o;
  logic ready_and_i;
  logic [vaddr_width_p-1:0] pc_o;
  logic [fetch_width_p+15:0] instr_o;
  logic [cnt_w-1:0] count_o;
  logic partial_v_o;
  logic seq_err_o;
  modport master (
    output fetch_v_i, fetch_pc_i, fetch_data_i, ready_and_i,
    input fetch_ready_and_o, v_o, pc_o, instr_o, count_o, partial_v_o, seq_err_o
  );
  modport slave (
    input fetch_v_i, fetch_pc_i, fetch_data_i, ready_and_i,
    output fetch_ready_and_o, v_o, pc_o, instr_o, count_o, partial_v_o, seq_err_o
  );
endinterface

// File: rtl/bp_fe_realigner.sv
// bp_fe_realigner: packs fetch blocks into halfword-aligned packets of whole instructions
module bp_fe_realigner #(
  parameter int vaddr_width_p = 39,
  parameter int fetch_width_p = 32
) (
  input logic clk_i,
  input logic reset_i,
  input logic flush_i,
  bp_fe_realigner_if.slave bus
);
  localparam int h = fetch_width_p/16;
  localparam int off_w = $clog2(h);
  localparam int cnt_w = $clog2(h + 2);
  logic partial_v_r, v_r, seq_err_r;
  logic [vaddr_width_p-1:0] partial_pc_r, pc_r;
  logic [15:0] partial_hw_r;
  logic [fetch_width_p+15:0] instr_r, n_instr;
  logic [cnt_w-1:0] cnt_r;
  logic [off_w-1:0] off;
  logic [vaddr_width_p-1:0] base, n_pc;
  logic seq, take, accept;
  logic [15:0] take_hw, hw;
  int nxt, cnt;
  assign off = bus.fetch_pc_i[off_w:1];
  assign base = {bus.fetch_pc_i[vaddr_width_p-1:off_w+1], {(off_w+1){1'b0}}};
  assign seq = partial_v_r && off == '0 && base == partial_pc_r + vaddr_width_p'(2);
  assign n_pc = seq ? partial_pc_r : bus.fetch_pc_i & ~vaddr_width_p'(1);
  assign bus.fetch_ready_and_o = ~flush_i & (~v_r | bus.ready_and_i);
  assign accept = bus.fetch_v_i & bus.fetch_ready_and_o;
  // A held residue pairs with halfword 0 of the next sequential block, so scanning resumes at 1
  always_comb begin
    n_instr = '0;
    take = 1'b0;
    take_hw = '0;
    hw = '0;
    nxt = seq ? 1 : int'(off);
    cnt = seq ? 2 : 0;
    if (seq) n_instr[31:0] = {bus.fetch_data_i[15:0], partial_hw_r};
    for (int k = 0; k < h; k++) begin
      if (k == nxt) begin
        hw = bus.fetch_data_i[16*k +: 16];
        if (hw[1:0] != 2'b11) begin
          n_instr[16*cnt +: 16] = hw;
          cnt = cnt + 1;
          nxt = k + 1;
        end else if (k + 1 < h) begin
          n_instr[16*cnt +: 16] = hw;
          n_instr[16*(cnt+1) +: 16] = bus.fetch_data_i[16*((k+1)%h) +: 16];
          cnt = cnt + 2;
          nxt = k + 2;
        end else begin
          take = 1'b1;
          take_hw = hw;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r <= 1'b0;
      pc_r <= '0;
      instr_r <= '0;
      cnt_r <= '0;
      partial_v_r <= 1'b0;
      partial_pc_r <= '0;
      partial_hw_r <= '0;
      seq_err_r <= 1'b0;
    end else if (flush_i) begin
      v_r <= 1'b0;
      partial_v_r <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      if (bus.ready_and_i) v_r <= 1'b0;
      if (accept) begin
        if (cnt != 0) begin
          v_r <= 1'b1;
          pc_r <= n_pc;
          instr_r <= n_instr;
          cnt_r <= cnt_w'(cnt);
        end
        partial_v_r <= take;
        if (take) begin
          partial_pc_r <= {bus.fetch_pc_i[vaddr_width_p-1:off_w+1], {off_w{1'b1}}, 1'b0};
          partial_hw_r <= take_hw;
        end
        if (partial_v_r && !seq) seq_err_r <= 1'b1;
      end
    end
  end
  assign bus.v_o = v_r;
  assign bus.pc_o = pc_r;
  assign bus.instr_o = instr_r;
  assign bus.count_o = cnt_r;
  assign bus.partial_v_o = partial_v_r;
  assign bus.seq_err_o = seq_err_r;
endmodule
